step_gen: RTL and testbench



---
 rtl/step_gen_pkg.sv | 28 ++
 rtl/step_gen_if.sv | 30 +++
 rtl/step_gen_channel.sv | 152 +++++++++++++++
 rtl/step_gen.sv | 92 +++++++++
 tb/tb_step_gen.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_gen_pkg.sv
// step_gen_pkg: shared definitions for the eight-channel step/direction
// generator.
//   - ch_state_e   : per-channel pulse sequencer states
//   - PEND_W/MAX/MIN: width and saturation limits of the pending net step count
//   - clamp_limit(): largest legal speed magnitude, 2^step_bit - 1
package step_gen_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIR_WAIT = 2'd1,
    ST_PULSE_HI = 2'd2,
    ST_PULSE_LO = 2'd3
  } ch_state_e;

  localparam int                       PEND_W   = 3;
  localparam logic signed [PEND_W-1:0] PEND_MAX = 3'sd3;
  localparam logic signed [PEND_W-1:0] PEND_MIN = -3'sd3;

  // Any speed of magnitude below one full step per tick crosses at most one
  // integer boundary per tick, so one request per tick is enough.
  function automatic logic signed [127:0] clamp_limit(input int step_bit);
    return (128'sd1 <<< step_bit) - 128'sd1;
  endfunction

endpackage

// File: rtl/step_gen_if.sv
// step_gen_if: host-side register bus of step_gen.
//   pos_sel       : channel select for position read/load
//   pos_load      : load pos_in into position[pos_sel]
//   pos_in        : load value
//   pos_out       : registered position of channel pos_sel
//   overrun       : sticky per-channel overrun flags
//   clear_overrun : per-bit overrun clear
// POS_BITS must match the POS_BITS of the step_gen it is bound to.
interface step_gen_if
  import step_gen_pkg::*;
#(
  parameter int POS_BITS = 32
);
  logic        [SEL_W-1:0]    pos_sel;
  logic                       pos_load;
  logic signed [POS_BITS-1:0] pos_in;
  logic signed [POS_BITS-1:0] pos_out;
  logic        [NUM_CH-1:0]   overrun;
  logic        [NUM_CH-1:0]   clear_overrun;

  modport master (
    output pos_sel, pos_load, pos_in, clear_overrun,
    input  pos_out, overrun
  );

  modport slave (
    input  pos_sel, pos_load, pos_in, clear_overrun,
    output pos_out, overrun
  );
endinterface

// File: rtl/step_gen_channel.sv
// step_gen_channel: one step/direction channel.
//   clk, rst      : clock, asynchronous active-high reset
//   tick, enable  : integration strobe and channel run enable
//   speed         : signed speed, step units * 2^STEP_BIT per tick
//   pos_load/pos_in: position load (wins over a same-cycle step increment)
//   clear_overrun : clears the sticky overrun flag (set wins)
//   step, dir     : driver pins; dir 1 = negative
//   position      : absolute step position
//   overrun       : sticky clamp / pending-overflow flag
module step_gen_channel
  import step_gen_pkg::*;
#(
  parameter int SPEED_BITS  = 64,
  parameter int ACC_BITS    = 64,
  parameter int STEP_BIT    = 32,
  parameter int POS_BITS    = 32,
  parameter int PULSE_WIDTH = 16,
  parameter int DIR_SETUP   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         enable,
  input  logic signed [SPEED_BITS-1:0] speed,
  input  logic                         pos_load,
  input  logic signed [POS_BITS-1:0]   pos_in,
  input  logic                         clear_overrun,
  output logic                         step,
  output logic                         dir,
  output logic signed [POS_BITS-1:0]   position,
  output logic                         overrun
);

  localparam logic signed [ACC_BITS-1:0] SPD_MAX = ACC_BITS'(clamp_limit(STEP_BIT));
  localparam logic signed [ACC_BITS-1:0] SPD_MIN = -SPD_MAX;
  localparam logic signed [PEND_W:0]     P_ONE   = (PEND_W+1)'(1);
  localparam logic signed [POS_BITS-1:0] POS_ONE = POS_BITS'(1);
  localparam int CNT_MAX = (PULSE_WIDTH > DIR_SETUP) ? PULSE_WIDTH : DIR_SETUP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  function automatic logic signed [ACC_BITS-1:0] sat_speed(
    input logic signed [ACC_BITS-1:0] s
  );
    if (s > SPD_MAX) return SPD_MAX;
    if (s < SPD_MIN) return SPD_MIN;
    return s;
  endfunction

  function automatic logic pend_fits(input logic signed [PEND_W:0] v);
    return (v <= (PEND_W+1)'(PEND_MAX)) && (v >= (PEND_W+1)'(PEND_MIN));
  endfunction

  logic signed [ACC_BITS-1:0] acc, spd_ext, spd_eff, acc_next;
  logic                       clamp_hit, crossed, tick_en, drop, set_ovr;
  logic signed [PEND_W:0]     req, consumed, pend_base, pend_sum;
  logic signed [PEND_W-1:0]   pend, pend_nx;
  ch_state_e                  state, state_nx;
  logic [CNT_W-1:0]           cnt, cnt_nx;
  logic                       start_pulse, start_dir, want_neg;

  // Integration and step request
  always_comb begin
    spd_ext   = ACC_BITS'(speed);
    spd_eff   = sat_speed(spd_ext);
    clamp_hit = (spd_eff != spd_ext);
    tick_en   = tick & enable;
    acc_next  = acc + spd_eff;
    crossed   = (acc_next[ACC_BITS-1:STEP_BIT] != acc[ACC_BITS-1:STEP_BIT]);
    req       = '0;
    if (tick_en && crossed) req = spd_eff[ACC_BITS-1] ? -P_ONE : P_ONE;
  end

  // Pending net step count; an overflowing request is dropped, not clipped
  always_comb begin
    pend_base = (PEND_W+1)'(pend) - consumed;
    pend_sum  = pend_base + req;
    drop      = 1'b0;
    pend_nx   = PEND_W'(pend_sum);
    if (!pend_fits(pend_sum)) begin
      drop    = 1'b1;
      pend_nx = PEND_W'(pend_base);
    end
    if (!enable) begin
      pend_nx = '0;
      drop    = 1'b0;
    end
    set_ovr = drop | (tick_en & clamp_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      pend     <= '0;
      overrun  <= 1'b0;
      position <= '0;
    end else begin
      if (tick_en) acc <= acc_next;
      pend <= pend_nx;
      if (set_ovr)            overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
      if (pos_load)         position <= pos_in;
      else if (start_pulse) position <= position + (dir ? -POS_ONE : POS_ONE);
    end
  end

  // Sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start_dir) dir <= ~dir;
    end
  end

  // Sequencer: next state
  always_comb begin
    want_neg = pend[PEND_W-1];
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (pend != '0) state_nx = (dir != want_neg) ? ST_DIR_WAIT : ST_PULSE_HI;
      end
      ST_DIR_WAIT: if (cnt == '0) state_nx = ST_IDLE;
      ST_PULSE_HI: if (cnt == '0) state_nx = ST_PULSE_LO;
      ST_PULSE_LO: if (cnt == '0) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Sequencer: outputs. step is decoded from state so an async reset drops
  // it without waiting for a clock edge.
  always_comb begin
    step        = (state == ST_PULSE_HI);
    start_pulse = (state == ST_IDLE) && (state_nx == ST_PULSE_HI);
    start_dir   = (state == ST_IDLE) && (state_nx == ST_DIR_WAIT);
    consumed    = '0;
    if (start_pulse) consumed = dir ? -P_ONE : P_ONE;
    cnt_nx = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    if (state_nx != state) begin
      case (state_nx)
        ST_DIR_WAIT:              cnt_nx = CNT_W'(DIR_SETUP - 1);
        ST_PULSE_HI, ST_PULSE_LO: cnt_nx = CNT_W'(PULSE_WIDTH - 1);
        default:                  cnt_nx = '0;
      endcase
    end
  end

endmodule

// File: rtl/step_gen.sv
// step_gen: eight-channel step/direction pulse generator.
//   clk, rst         : clock, asynchronous active-high reset
//   tick             : shared integration strobe
//   enable[7:0]      : per-channel run enable
//   speed_0..speed_7 : signed per-channel speeds
//   step[7:0], dir[7:0]: driver pins (dir 1 = negative)
//   bus              : host position read/load and overrun flags
module step_gen
  import step_gen_pkg::*;
#(
  parameter int SPEED_BITS  = 64,
  parameter int ACC_BITS    = 64,
  parameter int STEP_BIT    = 32,
  parameter int POS_BITS    = 32,
  parameter int PULSE_WIDTH = 16,
  parameter int DIR_SETUP   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic        [NUM_CH-1:0]     enable,
  input  logic signed [SPEED_BITS-1:0] speed_0,
  input  logic signed [SPEED_BITS-1:0] speed_1,
  input  logic signed [SPEED_BITS-1:0] speed_2,
  input  logic signed [SPEED_BITS-1:0] speed_3,
  input  logic signed [SPEED_BITS-1:0] speed_4,
  input  logic signed [SPEED_BITS-1:0] speed_5,
  input  logic signed [SPEED_BITS-1:0] speed_6,
  input  logic signed [SPEED_BITS-1:0] speed_7,
  output logic        [NUM_CH-1:0]     step,
  output logic        [NUM_CH-1:0]     dir,
  step_gen_if.slave                    bus
);

  logic signed [SPEED_BITS-1:0] speed    [NUM_CH];
  logic signed [POS_BITS-1:0]   position [NUM_CH];
  logic        [NUM_CH-1:0]     load;
  logic        [NUM_CH-1:0]     ovr;
  logic signed [POS_BITS-1:0]   pos_q;

  always_comb begin
    speed[0] = speed_0;
    speed[1] = speed_1;
    speed[2] = speed_2;
    speed[3] = speed_3;
    speed[4] = speed_4;
    speed[5] = speed_5;
    speed[6] = speed_6;
    speed[7] = speed_7;
  end

  always_comb begin
    load = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      load[ch] = bus.pos_load && (bus.pos_sel == SEL_W'(ch));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    step_gen_channel #(
      .SPEED_BITS (SPEED_BITS),
      .ACC_BITS   (ACC_BITS),
      .STEP_BIT   (STEP_BIT),
      .POS_BITS   (POS_BITS),
      .PULSE_WIDTH(PULSE_WIDTH),
      .DIR_SETUP  (DIR_SETUP)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .enable       (enable[g]),
      .speed        (speed[g]),
      .pos_load     (load[g]),
      .pos_in       (bus.pos_in),
      .clear_overrun(bus.clear_overrun[g]),
      .step         (step[g]),
      .dir          (dir[g]),
      .position     (position[g]),
      .overrun      (ovr[g])
    );
  end

  // Position read-back register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_q <= '0;
    else     pos_q <= position[bus.pos_sel];
  end

  assign bus.pos_out = pos_q;
  assign bus.overrun = ovr;

endmodule

// File: tb/tb_step_gen.sv
module tb_step_gen;
  localparam int     PW  = 16;
  localparam int     DS  = 32;
  localparam int     PB  = 32;
  localparam longint LIM = 64'sd4294967295;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0;
  logic [7:0]          enable = 8'h00;
  logic signed [63:0]  spd [8];
  logic [7:0]          step, dir;

  step_gen_if #(.POS_BITS(PB)) bus ();

  step_gen #(.SPEED_BITS(64), .ACC_BITS(64), .STEP_BIT(32), .POS_BITS(PB),
             .PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable),
    .speed_0(spd[0]), .speed_1(spd[1]), .speed_2(spd[2]), .speed_3(spd[3]),
    .speed_4(spd[4]), .speed_5(spd[5]), .speed_6(spd[6]), .speed_7(spd[7]),
    .step(step), .dir(dir), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pin monitor: counts pulses, signed position from pins, timing violations
  int mon_pos [8], rises [8], viol [8], hi_len [8], lo_len [8], since_dir [8];
  logic [7:0] pstep = '0, pdir = '0;

  always @(negedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if (rst) begin
        mon_pos[c] = 0; rises[c] = 0; hi_len[c] = 0;
        lo_len[c] = 1000; since_dir[c] = 1000;
      end else begin
        if (dir[c] != pdir[c]) begin
          if (step[c]) viol[c]++;
          since_dir[c] = 0;
        end else if (since_dir[c] < 1000) since_dir[c]++;
        if (step[c] && !pstep[c]) begin
          rises[c]++;
          mon_pos[c] += dir[c] ? -1 : 1;
          if (since_dir[c] < DS + 1) viol[c]++;
          if (lo_len[c] < PW) viol[c]++;
          hi_len[c] = 1;
        end else if (step[c]) begin
          hi_len[c]++;
        end else if (pstep[c]) begin
          if (hi_len[c] != PW) viol[c]++;
          lo_len[c] = 1;
        end else if (lo_len[c] < 1000) lo_len[c]++;
      end
    end
    pstep = step;
    pdir  = dir;
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; enable = 8'h00;
    for (int c = 0; c < 8; c++) spd[c] = 64'sd0;
    bus.pos_sel = '0; bus.pos_load = 1'b0; bus.pos_in = '0; bus.clear_overrun = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic read_pos(input int c, output longint v);
    bus.pos_sel = 3'(c);
    cyc(2);
    v = longint'($signed(bus.pos_out));
  endtask

  function automatic longint rand_speed();
    case ($urandom_range(0, 4))
      0: return longint'($urandom);
      1: return -longint'($urandom);
      2: return longint'({$urandom, $urandom});
      3: return (longint'($urandom_range(0, 12)) - 64'sd4) * 64'sd1073741824;
      default: return 64'sd0;
    endcase
  endfunction

  typedef struct {
    int     ch;
    longint a;
    longint b;
    longint exp_pos;
    bit     exp_ov;
  } vec_t;

  vec_t   vt [8];
  longint v;
  longint macc [8], mpos [8];
  bit     mov  [8];

  initial begin
    for (int c = 0; c < 8; c++) viol[c] = 0;
    // two ticks (speed a, then speed b) on one channel -> net position, overrun
    vt[0] = '{6, 64'sd0,          64'sd2147483648,  64'sd0,  1'b0};
    vt[1] = '{7, 64'sd2147483648, 64'sd2147483648,  64'sd1,  1'b0};
    vt[2] = '{0, 64'sd1,          64'sd8589934592,  64'sd1,  1'b1};
    vt[3] = '{1, 64'sd0,          -64'sd1,          -64'sd1, 1'b0};
    vt[4] = '{2, 64'sd0,          -64'sd8589934592, -64'sd1, 1'b1};
    vt[5] = '{3, LIM,             LIM,              64'sd1,  1'b0};
    vt[6] = '{4, -64'sd1,         64'sd1,           64'sd0,  1'b0};
    vt[7] = '{5, 64'sd4294967296, 64'sd0,           64'sd0,  1'b1};

    do_reset();
    check("reset step", longint'(step), 0);
    check("reset dir", longint'(dir), 0);
    check("reset overrun", longint'(bus.overrun), 0);
    check("reset pos_out", longint'($signed(bus.pos_out)), 0);

    foreach (vt[i]) begin
      do_reset();
      enable = 8'hFF;
      spd[vt[i].ch] = vt[i].a;
      pulse_tick();
      cyc(80);
      spd[vt[i].ch] = vt[i].b;
      pulse_tick();
      cyc(80);
      read_pos(vt[i].ch, v);
      check($sformatf("vec%0d pos", i), v, vt[i].exp_pos);
      check($sformatf("vec%0d overrun", i), longint'(bus.overrun[vt[i].ch]), longint'(vt[i].exp_ov));
      check($sformatf("vec%0d pin pos", i), longint'(mon_pos[vt[i].ch]), vt[i].exp_pos);
    end

    // normal stepping, ch0
    do_reset();
    enable = 8'hFF;
    spd[0] = 64'sd2147483648;
    repeat (8) begin pulse_tick(); cyc(63); end
    check("ch0 pulses", longint'(rises[0]), 4);
    check("ch0 dir", longint'(dir[0]), 0);
    read_pos(0, v);
    check("ch0 pos", v, 4);

    // direction change, ch1
    do_reset();
    enable = 8'hFF;
    spd[1] = LIM;
    repeat (2) begin pulse_tick(); cyc(80); end
    spd[1] = -LIM;
    repeat (2) begin pulse_tick(); cyc(80); end
    check("ch1 pulses", longint'(rises[1]), 2);
    check("ch1 dir", longint'(dir[1]), 1);
    read_pos(1, v);
    check("ch1 pos", v, 0);

    // clamp and overrun clear, ch2
    do_reset();
    enable = 8'hFF;
    spd[2] = 64'sd1;
    pulse_tick();
    spd[2] = 64'sd8589934592;
    pulse_tick();
    cyc(80);
    check("ch2 pulses", longint'(rises[2]), 1);
    check("ch2 overrun set", longint'(bus.overrun[2]), 1);
    bus.clear_overrun = 8'h04;
    cyc(1);
    bus.clear_overrun = 8'h00;
    check("ch2 overrun cleared", longint'(bus.overrun[2]), 0);
    bus.clear_overrun = 8'h04;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    bus.clear_overrun = 8'h00;
    check("ch2 set beats clear", longint'(bus.overrun[2]), 1);
    cyc(80);

    // pending saturation, ch3
    do_reset();
    enable = 8'hFF;
    spd[3] = LIM;
    tick = 1'b1;
    cyc(5);
    check("ch3 no overrun at 3 pending", longint'(bus.overrun[3]), 0);
    cyc(1);
    tick = 1'b0;
    check("ch3 overrun", longint'(bus.overrun[3]), 1);
    cyc(200);
    check("ch3 pulses", longint'(rises[3]), 4);
    read_pos(3, v);
    check("ch3 pos", v, 4);

    // position load coinciding with a pulse start, ch4
    do_reset();
    enable = 8'hFF;
    spd[4] = 64'sd2147483648;
    pulse_tick();
    cyc(10);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    bus.pos_sel = 3'd4; bus.pos_in = 32'sd1000; bus.pos_load = 1'b1;
    cyc(1);
    bus.pos_load = 1'b0;
    check("ch4 pulse with load", longint'(step[4]), 1);
    cyc(2);
    check("ch4 load wins", longint'($signed(bus.pos_out)), 1000);
    cyc(60);
    pulse_tick(); cyc(70);
    pulse_tick(); cyc(70);
    read_pos(4, v);
    check("ch4 continues", v, 1001);

    // async reset mid-pulse, ch5
    do_reset();
    enable = 8'hFF;
    bus.pos_sel = 3'd5;
    spd[5] = -64'sd8589934592;
    pulse_tick();
    for (int k = 0; k < 100 && !step[5]; k++) cyc(1);
    check("ch5 pulse before rst", longint'(step[5]), 1);
    cyc(3);
    check("ch5 dir before rst", longint'(dir[5]), 1);
    check("ch5 pos before rst", longint'($signed(bus.pos_out)), -1);
    #2 rst = 1'b1;
    #1;
    check("rst step", longint'(step), 0);
    check("rst dir", longint'(dir), 0);
    check("rst overrun", longint'(bus.overrun), 0);
    check("rst pos_out", longint'($signed(bus.pos_out)), 0);
    cyc(1);
    rst = 1'b0;
    spd[5] = 64'sd0;
    cyc(100);
    check("ch5 idle after rst", longint'(rises[5]), 0);

    // randomized traffic against the arithmetic model
    do_reset();
    for (int c = 0; c < 8; c++) begin macc[c] = 0; mpos[c] = 0; mov[c] = 1'b0; end
    for (int it = 0; it < 40; it++) begin
      enable = 8'($urandom);
      for (int c = 0; c < 8; c++) begin
        longint s, na;
        spd[c] = rand_speed();
        if (enable[c]) begin
          s = spd[c];
          if (s > LIM)  begin s = LIM;  mov[c] = 1'b1; end
          if (s < -LIM) begin s = -LIM; mov[c] = 1'b1; end
          na = macc[c] + s;
          if ((na >>> 32) != (macc[c] >>> 32)) mpos[c] += (s < 0) ? -1 : 1;
          macc[c] = na;
        end
      end
      pulse_tick();
      cyc(80);
    end
    for (int c = 0; c < 8; c++) begin
      read_pos(c, v);
      check($sformatf("rand ch%0d pos", c), v, longint'(int'(mpos[c])));
      check($sformatf("rand ch%0d pin pos", c), longint'(mon_pos[c]), mpos[c]);
      check($sformatf("rand ch%0d overrun", c), longint'(bus.overrun[c]), longint'(mov[c]));
    end

    for (int c = 0; c < 8; c++)
      check($sformatf("ch%0d pin timing", c), longint'(viol[c]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
